// File: rtl/mips_fetch_predictor.sv
// Instruction-fetch stage: PC register plus direct-mapped 2-bit branch predictor table,
// fetch-time jump redirect, predicted-taken branch redirect and mispredict recovery.
module mips_fetch_predictor #(
    parameter int          ENTRIES      = 16,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          PC_INCREMENT = 4,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [31:0]          instr_in,
    input  logic                 resolve_valid,
    input  logic [31:0]          resolve_pc,
    input  logic                 resolve_taken,
    input  logic                 resolve_predicted,
    input  logic [31:0]          resolve_target,
    output logic [31:0]          pc_out,
    output logic [31:0]          pc_plus_4_out,
    output logic                 predicted_taken_out,
    output logic                 flush_out,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int          IDX     = $clog2(ENTRIES);
    localparam logic [31:0] PC_STEP = 32'(PC_INCREMENT);

    typedef logic [1:0] ctr_t;

    function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
        if (taken)
            return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [31:0]          pc_p0;
    ctr_t                 ctr_p0 [ENTRIES];
    logic [CNT_WIDTH-1:0] branch_cnt_p0;
    logic [CNT_WIDTH-1:0] mispredict_cnt_p0;

    logic [5:0]        op;
    logic              is_branch;
    logic              is_jump;
    logic [IDX-1:0]    fetch_idx;
    logic [IDX-1:0]    update_idx;
    logic [31:0]       pc_plus_4;
    logic signed [31:0] branch_off;
    logic [31:0]       branch_target;
    logic [31:0]       jump_target;
    logic              pred_taken;
    logic              flush;
    logic [31:0]       next_pc;

    always_comb begin
        op            = instr_in[31:26];
        is_branch     = (op == 6'h04) || (op == 6'h05);
        is_jump       = (op == 6'h02) || (op == 6'h03);
        fetch_idx     = pc_p0[IDX+1:2];
        update_idx    = resolve_pc[IDX+1:2];
        pc_plus_4     = pc_p0 + PC_STEP;
        branch_off    = {{14{instr_in[15]}}, instr_in[15:0], 2'b00};
        branch_target = pc_plus_4 + $unsigned(branch_off);
        jump_target   = {pc_plus_4[31:28], instr_in[25:0], 2'b00};
        // Prediction reads the pre-update counter even when the same entry resolves this cycle.
        pred_taken    = is_branch & ctr_p0[fetch_idx][1];
        flush         = resolve_valid & (resolve_taken != resolve_predicted);

        next_pc = pc_plus_4;
        if (flush)
            next_pc = resolve_taken ? resolve_target : resolve_pc + PC_STEP;
        else if (stall)
            next_pc = pc_p0;
        else if (is_jump)
            next_pc = jump_target;
        else if (pred_taken)
            next_pc = branch_target;
    end

    // p0: fetch PC, predictor table and statistics
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_p0             <= RESET_PC;
            branch_cnt_p0     <= '0;
            mispredict_cnt_p0 <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr_p0[i] <= 2'b01;
        end else begin
            pc_p0 <= next_pc;
            if (resolve_valid) begin
                ctr_p0[update_idx] <= ctr_step(ctr_p0[update_idx], resolve_taken);
                branch_cnt_p0      <= sat_inc(branch_cnt_p0);
            end
            if (flush)
                mispredict_cnt_p0 <= sat_inc(mispredict_cnt_p0);
        end
    end

    assign pc_out              = pc_p0;
    assign pc_plus_4_out       = pc_plus_4;
    assign predicted_taken_out = pred_taken;
    assign flush_out           = flush;
    assign branch_count        = branch_cnt_p0;
    assign mispredict_count    = mispredict_cnt_p0;

endmodule

// File: tb/tb_mips_fetch_predictor.sv
// Directed and randomized checks of mips_fetch_predictor against an array-based reference model.
module tb_mips_fetch_predictor;

    localparam int          ENTRIES  = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] BEQ3     = 32'h1000_0003;

    logic        clk = 1'b0;
    logic        reset, stall, resolve_valid, resolve_taken, resolve_predicted;
    logic [31:0] instr_in, resolve_pc, resolve_target;
    logic [31:0] pc_out, pc_plus_4_out, pc_out4, pc_plus_4_out4;
    logic        predicted_taken_out, flush_out, pred4, flush4;
    logic [15:0] branch_count, mispredict_count;
    logic [3:0]  branch_count4, mispredict_count4;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_pc;
    int          m_ctr [ENTRIES];
    int          m_bc, m_mc, m_bc4, m_mc4;
    bit          m_valid = 0;

    mips_fetch_predictor #(.ENTRIES(ENTRIES), .RESET_PC(RESET_PC), .PC_INCREMENT(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .instr_in(instr_in),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_predicted(resolve_predicted), .resolve_target(resolve_target),
        .pc_out(pc_out), .pc_plus_4_out(pc_plus_4_out), .predicted_taken_out(predicted_taken_out),
        .flush_out(flush_out), .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    mips_fetch_predictor #(.ENTRIES(ENTRIES), .RESET_PC(RESET_PC), .PC_INCREMENT(4), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .stall(stall), .instr_in(instr_in),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_predicted(resolve_predicted), .resolve_target(resolve_target),
        .pc_out(pc_out4), .pc_plus_4_out(pc_plus_4_out4), .predicted_taken_out(pred4),
        .flush_out(flush4), .branch_count(branch_count4), .mispredict_count(mispredict_count4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: compare combinational and registered outputs at the falling edge, then advance the model.
    task automatic step();
        logic [5:0]  op;
        bit          is_br, is_j, e_pred, e_flush;
        int          idx, ridx;
        logic [31:0] pc4, nxt, off;
        @(negedge clk);
        op      = instr_in[31:26];
        is_br   = (op == 6'h04) || (op == 6'h05);
        is_j    = (op == 6'h02) || (op == 6'h03);
        idx     = int'(m_pc >> 2) % ENTRIES;
        pc4     = m_pc + 32'd4;
        e_pred  = is_br && (m_ctr[idx] >= 2);
        e_flush = resolve_valid && (resolve_taken != resolve_predicted);
        if (m_valid) begin
            chk("pc", pc_out, m_pc);
            chk("pc_plus_4", pc_plus_4_out, pc4);
            chk("predicted", {31'b0, predicted_taken_out}, {31'b0, e_pred});
            chk("flush", {31'b0, flush_out}, {31'b0, e_flush});
            chk("branch_count", {16'b0, branch_count}, m_bc);
            chk("mispredict_count", {16'b0, mispredict_count}, m_mc);
            chk("branch_count4", {28'b0, branch_count4}, m_bc4);
            chk("mispredict_count4", {28'b0, mispredict_count4}, m_mc4);
        end
        if (!reset) begin
            m_pc = RESET_PC;
            for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
            m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
            m_valid = 1;
        end else if (m_valid) begin
            off = {{14{instr_in[15]}}, instr_in[15:0], 2'b00};
            if (e_flush)     nxt = resolve_taken ? resolve_target : resolve_pc + 32'd4;
            else if (stall)  nxt = m_pc;
            else if (is_j)   nxt = {pc4[31:28], instr_in[25:0], 2'b00};
            else if (e_pred) nxt = pc4 + off;
            else             nxt = pc4;
            m_pc = nxt;
            if (resolve_valid) begin
                ridx = int'(resolve_pc >> 2) % ENTRIES;
                m_ctr[ridx] = resolve_taken ? ((m_ctr[ridx] < 3) ? m_ctr[ridx] + 1 : 3)
                                            : ((m_ctr[ridx] > 0) ? m_ctr[ridx] - 1 : 0);
                m_bc  = (m_bc < 65535) ? m_bc + 1 : 65535;
                m_bc4 = (m_bc4 < 15) ? m_bc4 + 1 : 15;
            end
            if (e_flush) begin
                m_mc  = (m_mc < 65535) ? m_mc + 1 : 65535;
                m_mc4 = (m_mc4 < 15) ? m_mc4 + 1 : 15;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Force the fetch PC to addr through a taken-mispredict on an unrelated table entry.
    task automatic goto_pc(input logic [31:0] addr);
        instr_in = 32'h0; stall = 1'b0;
        resolve_valid = 1'b1; resolve_pc = 32'h3C; resolve_taken = 1'b1;
        resolve_predicted = 1'b0; resolve_target = addr;
        step();
        resolve_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; instr_in = 32'h0;
        resolve_valid = 1'b0; resolve_pc = 32'h0; resolve_taken = 1'b0;
        resolve_predicted = 1'b0; resolve_target = 32'h0;

        // reset and sequential fetch
        step(); step();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_bc", {16'b0, branch_count}, 32'h0);
        chk("rst_mc", {16'b0, mispredict_count}, 32'h0);
        reset = 1'b1;
        step(); chk("seq_pc4", pc_out, 32'h4);
        step(); chk("seq_pc8", pc_out, 32'h8);
        step(); chk("seq_pcC", pc_out, 32'hC);
        stall = 1'b1;
        repeat (3) begin step(); chk("stall_hold", pc_out, 32'hC); end
        stall = 1'b0;

        // cold mispredict, then learned prediction
        reset = 1'b0; step(); reset = 1'b1; step(); step();
        chk("cold_at8", pc_out, 32'h8);
        instr_in = BEQ3; step(); chk("cold_fallthru", pc_out, 32'hC);
        instr_in = 32'h0;
        resolve_valid = 1'b1; resolve_pc = 32'h8; resolve_taken = 1'b1;
        resolve_predicted = 1'b0; resolve_target = 32'h18;
        step(); resolve_valid = 1'b0;
        chk("cold_redirect", pc_out, 32'h18);
        chk("cold_mc", {16'b0, mispredict_count}, 32'h1);
        goto_pc(32'h8);
        instr_in = BEQ3; step(); chk("learned_redirect", pc_out, 32'h18);

        // jump
        instr_in = 32'h0; goto_pc(32'h10);
        instr_in = 32'h0800_0040; step(); chk("jump_target", pc_out, 32'h100);
        instr_in = 32'h0;

        // saturation: ctr[2] is 2 here; four taken saturate at 3, two not-taken leave 1
        resolve_valid = 1'b1; resolve_pc = 32'h8; resolve_taken = 1'b1; resolve_predicted = 1'b1;
        repeat (4) step();
        resolve_taken = 1'b0; resolve_predicted = 1'b0;
        repeat (2) step();
        resolve_valid = 1'b0;
        goto_pc(32'h8);
        instr_in = BEQ3; step(); chk("sat_weak_nt", pc_out, 32'hC);
        instr_in = 32'h0;
        resolve_valid = 1'b1; resolve_pc = 32'h8; resolve_taken = 1'b1; resolve_predicted = 1'b1;
        repeat (2) step();
        resolve_valid = 1'b0;
        goto_pc(32'h8);
        instr_in = BEQ3; step(); chk("sat_taken", pc_out, 32'h18);
        instr_in = 32'h0;
        resolve_valid = 1'b1; resolve_pc = 32'h8; resolve_taken = 1'b0; resolve_predicted = 1'b1;
        step(); resolve_valid = 1'b0;
        chk("nt_recover", pc_out, 32'hC);

        // flush beats stall
        stall = 1'b1; resolve_valid = 1'b1; resolve_pc = 32'h20; resolve_taken = 1'b1;
        resolve_predicted = 1'b0; resolve_target = 32'h40;
        step(); stall = 1'b0; resolve_valid = 1'b0;
        chk("flush_over_stall", pc_out, 32'h40);

        // same-index read and write: prediction uses the old counter
        reset = 1'b0; step(); reset = 1'b1; step(); step();
        instr_in = BEQ3; resolve_valid = 1'b1; resolve_pc = 32'h8;
        resolve_taken = 1'b1; resolve_predicted = 1'b1;
        step(); resolve_valid = 1'b0; instr_in = 32'h0;
        chk("same_idx_old", pc_out, 32'hC);
        goto_pc(32'h8);
        instr_in = BEQ3; step(); instr_in = 32'h0;
        chk("same_idx_new", pc_out, 32'h18);

        // reset coincident with a mispredict
        resolve_valid = 1'b1; resolve_pc = 32'h8; resolve_taken = 1'b1;
        resolve_predicted = 1'b0; resolve_target = 32'h18; reset = 1'b0;
        step(); reset = 1'b1; resolve_valid = 1'b0;
        chk("rst_mid_pc", pc_out, RESET_PC);
        chk("rst_mid_bc", {16'b0, branch_count}, 32'h0);
        chk("rst_mid_mc", {16'b0, mispredict_count}, 32'h0);

        // statistics saturation in the narrow-counter instance
        resolve_valid = 1'b1; resolve_pc = 32'h4; resolve_taken = 1'b1;
        resolve_predicted = 1'b0; resolve_target = 32'h100;
        repeat (20) step();
        resolve_valid = 1'b0;
        chk("mc4_sat", {28'b0, mispredict_count4}, 32'hF);
        chk("bc4_sat", {28'b0, branch_count4}, 32'hF);
        chk("mc16_20", {16'b0, mispredict_count}, 32'd20);

        // address wrap
        goto_pc(32'hFFFF_FFFC);
        step(); chk("pc_wrap", pc_out, 32'h0);

        // randomized traffic
        repeat (500) begin
            logic [5:0] op;
            case ($urandom_range(0, 5))
                0: op = 6'h02;
                1: op = 6'h03;
                2: op = 6'h04;
                3: op = 6'h05;
                4: op = 6'h00;
                default: op = 6'($urandom);
            endcase
            instr_in          = {op, 26'($urandom)};
            reset             = ($urandom_range(0, 49) != 0);
            stall             = ($urandom_range(0, 3) == 0);
            resolve_valid     = 1'($urandom);
            resolve_pc        = {24'($urandom_range(0, 3) == 0 ? 24'hFFFFFF : 24'h0), 6'($urandom), 2'b00};
            resolve_taken     = 1'($urandom);
            resolve_predicted = 1'($urandom);
            resolve_target    = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_fetch_predictor.md
# mips_fetch_predictor

Parametrised instruction-fetch stage for the pipelined MIPS core. It replaces the plain PC register, PC adder and PC-source mux with a unit that adds a direct-mapped table of 2-bit saturating branch predictors. It also adds fetch-time redirection for `j`/`jal` and early redirection for predicted-taken `beq`/`bne`. The unit sits between the program ROM (combinational read of `pc_out`) and the IF/ID register; the ID stage reports branch resolutions back to it.

## Interface
- `ENTRIES`, 16: predictor table depth; power of two, ≥2. `IDX = log2(ENTRIES)`.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `PC_INCREMENT`, 4: sequential PC step.
- `CNT_WIDTH`, 16: width of the statistics counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low.
- `stall` in 1: hazard unit hold request; PC keeps its value.
- `instr_in` in 32: ROM word at `pc_out` (same cycle).
- `resolve_valid` in 1: ID stage resolves a conditional branch this cycle.
- `resolve_pc` in 32: PC of the resolving branch.
- `resolve_taken` in 1: actual outcome.
- `resolve_predicted` in 1: `predicted_taken_out` value carried with that branch through IF/ID.
- `resolve_target` in 32: computed taken target (pc+4 + signext(imm)<<2).
- `pc_out` out 32: current fetch PC (registered).
- `pc_plus_4_out` out 32: `pc_out + PC_INCREMENT`.
- `predicted_taken_out` out 1: the fetched instruction is a conditional branch predicted taken (combinational).
- `flush_out` out 1: mispredict; IF/ID must be cleared on this edge (combinational).
- `branch_count` out CNT_WIDTH: resolved branches, saturating.
- `mispredict_count` out CNT_WIDTH: mispredicts, saturating.

## Operation
- **Decode of `instr_in`:** `op = instr_in[31:26]`.
  - Conditional branch: `op` is 6'h04 (beq) or 6'h05 (bne).
  - Jump: `op` is 6'h02 (j) or 6'h03 (jal).
- **Table:** `ctr[ENTRIES]`, 2 bits each.
  - Fetch index = `pc_out[IDX+1:2]`; update index = `resolve_pc[IDX+1:2]`.
  - Predict taken when `ctr[idx][1] == 1`.
- **Fetch-side targets:**
  - Branch target = `pc_plus_4_out + {{14{instr_in[15]}}, instr_in[15:0], 2'b00}`.
  - Jump target = `{pc_plus_4_out[31:28], instr_in[25:0], 2'b00}`.
- **`predicted_taken_out`** = conditional branch AND `ctr[fetch idx][1]`. It is 0 for jumps and all other opcodes.
- **`flush_out`** = `resolve_valid & (resolve_taken != resolve_predicted)`.
- **Next-PC priority** (highest first):
  1. `reset == 0`: `RESET_PC`.
  2. `flush_out`: `resolve_taken ? resolve_target : resolve_pc + PC_INCREMENT`.
  3. `stall`: hold `pc_out`.
  4. Jump: jump target.
  5. `predicted_taken_out`: branch target.
  6. Otherwise: `pc_plus_4_out`.
- **Counter update** on every `resolve_valid` (independent of `stall`/`flush_out`):
  - Taken: increment, saturating at 2'b11.
  - Not taken: decrement, saturating at 2'b00.
- **Statistics:**
  - `branch_count` += 1 on each `resolve_valid`.
  - `mispredict_count` += 1 on each `flush_out`.
  - Both saturate at all-ones and never wrap.
- Jumps never appear on the resolve port. Jumps and predicted branches complete without a flush.

## Timing
- **Reset** (sampled on `clk` edge with `reset == 0`):
  - `pc_out = RESET_PC`.
  - All `ctr = 2'b01` (weakly not-taken).
  - `branch_count = mispredict_count = 0`.
  - `flush_out` and `predicted_taken_out` are then 0, given `resolve_valid == 0` and a non-branch `instr_in`.
  - Reset mid-redirect wins: the next PC is `RESET_PC`, and no counter or statistic updates on that edge.
- **Latency:**
  - `pc_out` changes one edge after the next-PC selection.
  - `predicted_taken_out` and `flush_out` are same-cycle combinational.
  - Prediction redirect costs 0 bubbles. Mispredict costs 1 flushed IF/ID slot.
- **Same-index read/write in one cycle:** the fetch prediction uses the old counter value; the new value is visible from the next cycle.
- **Two branches in different index sets alias on equal `pc[IDX+1:2]`.** This is accepted and intentional.
- **Address arithmetic** is modulo 2^32. `0xFFFF_FFFC + 4` wraps to 0.

## Test plan
- **Reset and sequential fetch:** hold `reset=0` for 2 cycles with `RESET_PC=0`, then release with NOPs. Expect `pc_out` 0, 4, 8, 0xC; counts 0; `flush_out=0`. Then `stall=1` for 3 cycles: `pc_out` holds 0xC.
- **Cold mispredict then learned prediction:** fetch beq at 0x8 with imm=3. Expect `predicted_taken_out=0` and next `pc_out=0xC`. Resolve `resolve_pc=0x8`, taken, predicted=0, target 0x18. Expect `flush_out=1`, next `pc_out=0x18`, `mispredict_count=1`, `ctr=10`. Refetch 0x8: expect `predicted_taken_out=1` and next `pc_out=0x18`.
- **Jump:** instr 0x0800_0040 at `pc_out=0x10`. Expect next `pc_out=0x100`, `predicted_taken_out=0`, `flush_out=0`.
- **Saturation:**
  - Four taken resolves on index 2 leave `ctr=11`; two not-taken leave `ctr=01`.
  - Predicted-taken but resolved not-taken at `resolve_pc=0x8` gives next `pc_out=0xC` and `flush_out=1`.
- **Priority:**
  - `flush_out` and `stall` together: PC takes the redirect target.
  - Resolve and fetch on the same index in the same cycle: prediction uses the old counter.
- **Reset mid-operation and counter saturation:**
  - `reset=0` coincident with a mispredict: `pc_out=RESET_PC` and counts 0.
  - With `CNT_WIDTH=4`: 20 mispredicts give `mispredict_count=4'hF`.
